// File: rtl/sum_collector.sv
// Show-ahead FIFO capturing {addr,sum} pairs from the adder, plus a 16-entry frame tracker.
// Optional running frame total is built only when SUM_COLLECTOR_TOTAL_EN is defined.
module sum_collector #(
  parameter int DW    = 9,
  parameter int AW    = 4,
  parameter int DEPTH = 8,
  parameter int TW    = 13
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_sum,
  input  logic [AW-1:0]            in_addr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DW-1:0]            out_sum,
  output logic [AW-1:0]            out_addr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_done,
  output logic                     seq_err,
  output logic                     dropped,
  output logic [TW-1:0]            total
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = AW + DW;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  logic [WW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CW-1:0] count_reg, count_next;
  logic [WW-1:0] head_reg, head_next, din;
  logic          full, empty, push, pop;

  state_t        state_reg, state_next;
  logic [AW-1:0] expected_reg, expected_next;
  logic          seq_err_reg, seq_err_next, dropped_reg;
  logic          start_frame, accumulate;

  assign din        = {in_addr, in_sum};
  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign push       = in_valid & ~full;
  assign pop        = out_ready & ~empty;
  assign rd_ptr_inc = rd_ptr_reg + PW'(1);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  // Head register is refreshed from the entry behind the one being popped,
  // or straight from the input when that entry would not yet be in memory.
  always_comb begin
    head_next = head_reg;
    if (pop) begin
      if (count_reg == CW'(1)) begin
        if (push) head_next = din;
      end else begin
        head_next = mem[rd_ptr_inc];
      end
    end else if (empty && push) begin
      head_next = din;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      head_reg    <= '0;
      dropped_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_next;
      head_reg  <= head_next;
      if (in_valid && full) dropped_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next    = (state_reg == DONE) ? IDLE : state_reg;
    expected_next = expected_reg;
    seq_err_next  = seq_err_reg;
    start_frame   = 1'b0;
    accumulate    = 1'b0;
    if (push) begin
      case (state_reg)
        COLLECT: begin
          if (in_addr == expected_reg) begin
            expected_next = expected_reg + AW'(1);
            accumulate    = 1'b1;
            if (in_addr == LAST_ADDR) state_next = DONE;
          end else begin
            seq_err_next = 1'b1;
            if (in_addr == '0) begin
              start_frame   = 1'b1;
              expected_next = AW'(1);
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: begin
          // IDLE and the DONE pulse cycle both wait for a frame start
          if (in_addr == '0) begin
            state_next    = COLLECT;
            expected_next = AW'(1);
            start_frame   = 1'b1;
          end else begin
            state_next   = IDLE;
            seq_err_next = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      expected_reg <= '0;
      seq_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      expected_reg <= expected_next;
      seq_err_reg  <= seq_err_next;
    end
  end

`ifdef SUM_COLLECTOR_TOTAL_EN
  logic [TW-1:0] total_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      total_reg <= '0;
    end else if (start_frame) begin
      total_reg <= TW'(in_sum);
    end else if (accumulate) begin
      total_reg <= total_reg + TW'(in_sum);
    end
  end

  assign total = total_reg;
`else
  logic unused_total;
  assign unused_total = start_frame | accumulate;
  assign total        = '0;
`endif

  assign in_ready   = ~full;
  assign out_valid  = ~empty;
  assign out_addr   = head_reg[WW-1:DW];
  assign out_sum    = head_reg[DW-1:0];
  assign count      = count_reg;
  assign frame_done = (state_reg == DONE);
  assign seq_err    = seq_err_reg;
  assign dropped    = dropped_reg;

endmodule
